mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum memory wait cycles before an access is aborted.
REQ-002 SHALL have parameter MAX_D_STREAK, default 4: maximum consecutive data grants while a fetch is pending.
REQ-003 SHALL have ports, one per line:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request; held high with stable if_addr until if_valid.
- if_addr  input  32  fetch word address.
- if_rdata  output  32  fetched instruction; valid while if_valid=1.
- if_valid  output  1  one-cycle fetch completion pulse.
- d_req  input  1  data request; held high with stable d_we/d_addr/d_wdata until d_valid.
- d_we  input  1  1=store, 0=load.
- d_addr  input  32  data address.
- d_wdata  input  32  store data.
- d_rdata  output  32  load data; valid while d_valid=1.
- d_valid  output  1  one-cycle data completion pulse.
- stall_if  output  1  combinational: if_req & ~if_valid.
- stall_mem  output  1  combinational: d_req & ~d_valid.
- mem_req  output  1  registered memory request.
- mem_we  output  1  registered write enable.
- mem_addr  output  32  registered address.
- mem_wdata  output  32  registered write data.
- mem_rdata  input  32  memory read data; sampled when mem_ready=1.
- mem_ready  input  1  memory completion; may assert in the first cycle of mem_req.
- bus_err  output  1  sticky timeout flag.

Function
REQ-004 SHALL implement FSM states IDLE, IF_ACC, D_ACC, DONE.
REQ-005 IDLE: d_req=1 and streak<MAX_D_STREAK -> D_ACC; else if_req=1 -> IF_ACC; else d_req=1 -> D_ACC; else stay IDLE.
REQ-006 Entering IF_ACC/D_ACC SHALL latch the requester's address, we (0 for fetch) and wdata into mem_* and set mem_req=1 on the same edge.
REQ-007 mem_req, mem_we, mem_addr and mem_wdata SHALL hold stable in IF_ACC/D_ACC until the edge that samples mem_ready=1.
REQ-008 On mem_ready=1 in IF_ACC/D_ACC: capture mem_rdata into if_rdata/d_rdata, clear mem_req, go to DONE.
REQ-009 DONE SHALL assert exactly the served requester's valid for one cycle, ignore all requests, and return to IDLE.
REQ-010 Minimum latency: req high before edge N -> mem_req high after N; mem_ready=1 in that cycle -> valid high for the cycle after N+1.
REQ-011 Wait counter SHALL clear on entering an ACC state and increment each ACC cycle with mem_ready=0.
REQ-012 When the wait counter reaches TIMEOUT-1 with mem_ready=0: clear mem_req, load rdata=0, set bus_err=1, go to DONE (valid still pulses).
REQ-013 Streak counter SHALL increment on each D_ACC entry while if_req=1, clear on IF_ACC entry or when if_req=0, and saturate at MAX_D_STREAK.
REQ-014 mem_wdata SHALL equal 0 in fetch accesses; d_wdata SHALL NOT reach memory when d_we=0.
REQ-015 A requester dropping req mid-access SHALL NOT abort it; the access completes and valid still pulses.
REQ-016 if_rdata and d_rdata SHALL hold their last value outside valid cycles.

Reset
REQ-017 reset=0 SHALL immediately force: IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_valid=0, d_valid=0, if_rdata=0, d_rdata=0, bus_err=0, both counters=0.
REQ-018 Reset during an ACC state SHALL abandon the access with no valid pulse; the first post-reset arbitration occurs on the first edge with reset=1.

Verification
REQ-019 if_req, if_addr=0x100; mem_ready=1 on the first mem_req cycle, mem_rdata=0x00500093 -> mem_addr=0x100, mem_we=0; if_valid 1 cycle, if_rdata=0x00500093, two cycles after req.
REQ-020 if_req and d_req (d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF) in the same cycle -> data served first with mem_we=1 and mem_wdata=0xDEADBEEF; fetch served next; stall_if high throughout.
REQ-021 if_req held, d_req re-raised every access -> exactly 4 data grants, then 1 fetch grant, then streak restarts.
REQ-022 d_req load, mem_ready held 0 -> mem_req drops after 16 cycles; d_valid pulses with d_rdata=0; bus_err=1 until reset.
REQ-023 reset=0 asserted mid-D_ACC -> mem_req=0 and all outputs 0 immediately, no d_valid; after release, pending if_req is granted normally.
REQ-024 mem_ready delayed 3 cycles -> mem_addr/mem_we/mem_wdata stable across all 4 request cycles; single valid pulse.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester (fetch/data) single-port memory arbiter
//
// Purpose: serialises instruction-fetch and data accesses onto one memory port.
// Data normally wins, but at most MAX_D_STREAK consecutive data grants are given
// while a fetch waits. A memory that stays silent for TIMEOUT cycles aborts the
// access with zero read data and raises the sticky bus_err flag.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   if_req/if_addr        fetch request (held until if_valid)
//   if_rdata/if_valid     fetch result and one-cycle completion pulse
//   d_req/d_we/d_addr/
//   d_wdata               data request (held until d_valid)
//   d_rdata/d_valid       data result and one-cycle completion pulse
//   stall_if/stall_mem    combinational stall indications to the pipeline
//   mem_req/mem_we/
//   mem_addr/mem_wdata    registered memory request, stable until mem_ready
//   mem_rdata/mem_ready   memory response
//   bus_err               sticky timeout flag
module mem_port_arbiter #(
    parameter int TIMEOUT      = 16,
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        bus_err
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(MAX_D_STREAK + 1);

    typedef enum logic [1:0] {
        IDLE,
        IF_ACC,
        D_ACC,
        DONE
    } state_t;

    state_t         state_q;
    logic           mem_req_q;
    logic           mem_we_q;
    logic [31:0]    mem_addr_q;
    logic [31:0]    mem_wdata_q;
    logic [31:0]    if_rdata_q;
    logic [31:0]    d_rdata_q;
    logic           if_valid_q;
    logic           d_valid_q;
    logic           bus_err_q;
    logic [WW-1:0]  wait_q;
    logic [SW-1:0]  streak_q;

    logic           grant_d;
    logic           grant_i;
    logic           streak_open;

    // Data may go when the streak budget is not used up, or when no fetch waits.
    assign streak_open = (streak_q < SW'(MAX_D_STREAK));
    assign grant_d     = d_req && (streak_open || !if_req);
    assign grant_i     = if_req && !grant_d;

    assign stall_if  = if_req & ~if_valid_q;
    assign stall_mem = d_req & ~d_valid_q;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign bus_err   = bus_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            wait_q      <= '0;
            streak_q    <= '0;
        end else begin
            // The streak only means something while a fetch is waiting.
            if (!if_req) begin
                streak_q <= '0;
            end

            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q     <= D_ACC;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_we ? d_wdata : 32'h0;
                        wait_q      <= '0;
                        if (!if_req) begin
                            streak_q <= '0;
                        end else if (streak_open) begin
                            streak_q <= streak_q + 1'b1;
                        end
                    end else if (grant_i) begin
                        state_q     <= IF_ACC;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= 32'h0;
                        wait_q      <= '0;
                        streak_q    <= '0;
                    end
                end

                IF_ACC, D_ACC: begin
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        state_q   <= DONE;
                        if (state_q == D_ACC) begin
                            d_rdata_q <= mem_rdata;
                            d_valid_q <= 1'b1;
                        end else begin
                            if_rdata_q <= mem_rdata;
                            if_valid_q <= 1'b1;
                        end
                    end else if (wait_q == WW'(TIMEOUT - 1)) begin
                        // Abort: the requester still gets its completion pulse.
                        mem_req_q <= 1'b0;
                        bus_err_q <= 1'b1;
                        state_q   <= DONE;
                        if (state_q == D_ACC) begin
                            d_rdata_q <= 32'h0;
                            d_valid_q <= 1'b1;
                        end else begin
                            if_rdata_q <= 32'h0;
                            if_valid_q <= 1'b1;
                        end
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end

                DONE: begin
                    if_valid_q <= 1'b0;
                    d_valid_q  <= 1'b0;
                    state_q    <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ready = 1'b0;
    logic        bus_err;

    mem_port_arbiter #(.TIMEOUT(16), .MAX_D_STREAK(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // scoreboard queues: expected memory-side access {we, addr, wdata} and completion data
    logic [64:0] acc_if_q[$];
    logic [64:0] acc_d_q[$];
    logic [31:0] exp_if_q[$];
    logic [31:0] exp_d_q[$];
    int          if_dly_q[$];
    int          d_dly_q[$];
    bit          grant_log[$];

    logic [31:0] ref_mem[logic [31:0]];
    int          last_req_cycles = 0;
    int          d_valid_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h100) return 32'h00500093;
        return a * 32'h9E3779B1;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return a ^ 32'hA5A50000;
    endfunction

    // ---------------- memory responder ----------------
    logic [31:0] mem_store[logic [31:0]];
    bit          rsp_busy = 1'b0;
    int          rsp_cnt = 0;

    initial mem_store[32'h100] = 32'h00500093;

    always @(negedge clk) begin
        if (!reset || !mem_req) begin
            rsp_busy  = 1'b0;
            mem_ready = 1'b0;
        end else begin
            if (!rsp_busy) begin
                rsp_busy = 1'b1;
                if (mem_addr[13]) begin
                    if (d_dly_q.size() == 0) begin
                        chk("rsp_d_delay_queue", 32'(d_dly_q.size()), 32'd1);
                        rsp_cnt = 0;
                    end else rsp_cnt = d_dly_q.pop_front();
                end else begin
                    if (if_dly_q.size() == 0) begin
                        chk("rsp_if_delay_queue", 32'(if_dly_q.size()), 32'd1);
                        rsp_cnt = 0;
                    end else rsp_cnt = if_dly_q.pop_front();
                end
            end else if (rsp_cnt > 0) begin
                rsp_cnt--;
            end
            if (rsp_cnt == 0) begin
                mem_ready = 1'b1;
                if (mem_we) begin
                    mem_store[mem_addr] = mem_wdata;
                    mem_rdata = ~mem_wdata;
                end else if (mem_store.exists(mem_addr)) begin
                    mem_rdata = mem_store[mem_addr];
                end else if (mem_addr[13]) begin
                    mem_rdata = mem_addr ^ 32'hA5A50000;
                end else begin
                    mem_rdata = mem_addr * 32'h9E3779B1;
                end
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
        end
    end

    // ---------------- monitor ----------------
    bit          prev_mem_req = 1'b0;
    bit          prev_if_req = 1'b0;
    bit          prev_d_req = 1'b0;
    bit          prev_if_valid = 1'b0;
    bit          prev_d_valid = 1'b0;
    int          m_streak = 0;
    int          req_cycles = 0;
    logic [64:0] cur_acc = '0;
    logic [31:0] last_if = '0;
    logic [31:0] last_d = '0;

    always @(negedge clk) begin
        if (!reset) begin
            prev_mem_req  = 1'b0;
            prev_if_valid = 1'b0;
            prev_d_valid  = 1'b0;
            prev_if_req   = if_req;
            prev_d_req    = d_req;
            m_streak      = 0;
            last_if       = '0;
            last_d        = '0;
        end else begin
            chk("stall_if", {31'h0, stall_if}, {31'h0, if_req & ~if_valid});
            chk("stall_mem", {31'h0, stall_mem}, {31'h0, d_req & ~d_valid});

            if (mem_req && !prev_mem_req) begin
                bit win_d;
                if (prev_d_req && prev_if_req) win_d = (m_streak < 4);
                else win_d = prev_d_req;
                if (!prev_d_req && !prev_if_req) chk("grant_without_request", 32'd1, 32'd0);
                chk("grant_port", {31'h0, mem_addr[13]}, {31'h0, win_d});
                grant_log.push_back(win_d);
                if (win_d ? (acc_d_q.size() == 0) : (acc_if_q.size() == 0)) begin
                    chk("grant_queue_empty", 32'd1, 32'd0);
                    cur_acc = {mem_we, mem_addr, mem_wdata};
                end else begin
                    cur_acc = win_d ? acc_d_q.pop_front() : acc_if_q.pop_front();
                    chk("mem_we", {31'h0, mem_we}, {31'h0, cur_acc[64]});
                    chk("mem_addr", mem_addr, cur_acc[63:32]);
                    chk("mem_wdata", mem_wdata, cur_acc[31:0]);
                end
                if (win_d) m_streak = prev_if_req ? ((m_streak < 4) ? m_streak + 1 : 4) : 0;
                else m_streak = 0;
                req_cycles = 1;
            end else if (mem_req && prev_mem_req) begin
                chk("mem_stable", {mem_we, mem_addr[30:0]} ^ mem_wdata,
                    {cur_acc[64], cur_acc[62:32]} ^ cur_acc[31:0]);
                req_cycles++;
            end else if (!mem_req && prev_mem_req) begin
                last_req_cycles = req_cycles;
            end

            if (if_valid) begin
                chk("if_valid_pulse", {31'h0, prev_if_valid}, 32'h0);
                chk("one_valid_only", {31'h0, d_valid}, 32'h0);
                if (exp_if_q.size() == 0) chk("if_valid_unexpected", 32'd1, 32'd0);
                else chk("if_rdata", if_rdata, exp_if_q.pop_front());
                last_if = if_rdata;
            end else begin
                chk("if_rdata_hold", if_rdata, last_if);
            end
            if (d_valid) begin
                d_valid_cnt++;
                chk("d_valid_pulse", {31'h0, prev_d_valid}, 32'h0);
                if (exp_d_q.size() == 0) chk("d_valid_unexpected", 32'd1, 32'd0);
                else chk("d_rdata", d_rdata, exp_d_q.pop_front());
                last_d = d_rdata;
            end else begin
                chk("d_rdata_hold", d_rdata, last_d);
            end

            if (!if_req) m_streak = 0;
            prev_mem_req  = mem_req;
            prev_if_req   = if_req;
            prev_d_req    = d_req;
            prev_if_valid = if_valid;
            prev_d_valid  = d_valid;
        end
    end

    // ---------------- requesters ----------------
    task automatic fetch_op(input logic [31:0] addr, input int dly, output int lat);
        acc_if_q.push_back({1'b0, addr, 32'h0});
        if_dly_q.push_back(dly);
        exp_if_q.push_back(rom(addr));
        if_req  = 1'b1;
        if_addr = addr;
        lat = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (if_valid) begin
                lat = i;
                break;
            end
        end
        tests++;
        if (lat == 0) begin
            fails++;
            $display("FAIL fetch_wait: no if_valid within 300 cycles, addr %h", addr);
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
    endtask

    task automatic data_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input int dly, output int lat);
        logic [31:0] exp;
        bit to;
        to = (dly >= 16);
        if (we) begin
            exp = to ? 32'h0 : ~wd;
            if (!to) ref_mem[addr] = wd;
        end else begin
            exp = to ? 32'h0 : ref_read(addr);
        end
        acc_d_q.push_back({we, addr, we ? wd : 32'h0});
        d_dly_q.push_back(dly);
        exp_d_q.push_back(exp);
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wd;
        lat = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (d_valid) begin
                lat = i;
                break;
            end
        end
        tests++;
        if (lat == 0) begin
            fails++;
            $display("FAIL data_wait: no d_valid within 300 cycles, addr %h", addr);
        end
        @(posedge clk);
        #1;
        d_req = 1'b0;
    endtask

    task automatic fetch_agent(input int n);
        int lat;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            fetch_op({20'h0, 10'($urandom_range(0, 1023)), 2'b00}, $urandom_range(0, 3), lat);
        end
    endtask

    task automatic data_agent(input int n);
        int lat;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            data_op(1'($urandom_range(0, 1)), 32'h2000 + {24'h0, 6'($urandom_range(0, 63)), 2'b00},
                    $urandom, $urandom_range(0, 3), lat);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int lat2;
        int dv_before;
        logic [7:0] gv;

        reset   = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_valids", {30'h0, if_valid, d_valid}, 32'h0);
        chk("rst_rdata", if_rdata | d_rdata, 32'h0);
        chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
        @(negedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;

        // minimum-latency fetch
        fetch_op(32'h100, 0, lat);
        chk("fetch_min_latency", lat, 3);
        repeat (2) @(posedge clk);
        #1;

        // simultaneous requests: data first, then fetch
        grant_log.delete();
        fork
            data_op(1'b1, 32'h2004, 32'hDEADBEEF, 0, lat);
            fetch_op(32'h200, 0, lat2);
        join
        chk("simul_grant_count", grant_log.size(), 2);
        if (grant_log.size() >= 2) chk("simul_order", {30'h0, grant_log[0], grant_log[1]}, 32'h2);
        chk("simul_data_latency", lat, 3);
        repeat (2) @(posedge clk);
        #1;

        // data streak limit while a fetch waits
        grant_log.delete();
        fork
            begin
                fetch_op(32'h300, 0, lat);
                fetch_op(32'h304, 0, lat);
            end
            begin
                for (int i = 0; i < 6; i++)
                    data_op(1'($urandom_range(0, 1)), 32'h2040 + 32'(i * 4), $urandom, 0, lat2);
            end
        join
        chk("streak_grant_count", grant_log.size(), 8);
        gv = '0;
        for (int i = 0; i < 8 && i < grant_log.size(); i++) gv[7-i] = grant_log[i];
        chk("streak_order", {24'h0, gv}, 32'hF6);
        repeat (2) @(posedge clk);
        #1;

        // randomized traffic
        fork
            fetch_agent(40);
            data_agent(40);
        join
        repeat (3) @(posedge clk);
        #1;
        chk("bus_err_clean", {31'h0, bus_err}, 32'h0);
        chk("if_queue_drained", exp_if_q.size(), 0);
        chk("d_queue_drained", exp_d_q.size(), 0);

        // timeout on a load
        data_op(1'b0, 32'h2010, $urandom, 99, lat);
        chk("timeout_req_cycles", last_req_cycles, 16);
        repeat (4) @(posedge clk);
        #1;
        chk("bus_err_sticky", {31'h0, bus_err}, 32'h1);

        // reset in the middle of a data access with a fetch pending
        acc_d_q.push_back({1'b0, 32'h2020, 32'h0});
        d_dly_q.push_back(99);
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h2020;
        d_wdata = $urandom;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mem_req) begin
                lat = i;
                break;
            end
        end
        chk("rst_test_granted", {31'h0, lat != 0}, 32'h1);
        @(posedge clk);
        #1;
        acc_if_q.push_back({1'b0, 32'h400, 32'h0});
        if_dly_q.push_back(0);
        exp_if_q.push_back(rom(32'h400));
        if_req  = 1'b1;
        if_addr = 32'h400;
        @(posedge clk);
        #3;
        dv_before = d_valid_cnt;
        reset = 1'b0;
        d_req = 1'b0;
        #1;
        chk("midrst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        chk("midrst_mem_we_wdata", {31'h0, mem_we} | mem_wdata, 32'h0);
        chk("midrst_valid_rdata", {30'h0, if_valid, d_valid} | if_rdata | d_rdata, 32'h0);
        chk("midrst_bus_err", {31'h0, bus_err}, 32'h0);
        @(negedge clk);
        #2 reset = 1'b1;
        lat = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (if_valid) begin
                lat = i;
                break;
            end
        end
        chk("post_reset_fetch_latency", lat, 2);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("no_d_valid_after_abort", d_valid_cnt, dv_before);
        chk("final_if_queue", exp_if_q.size(), 0);
        chk("final_d_queue", exp_d_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
